// File: rtl/dds_pwm_pkg.sv
// Shared constants, update-FSM encoding and duty saturation for the DDS/PWM core.
package dds_pwm_pkg;

  localparam int DUTY_W = 20;

  localparam logic [DUTY_W-1:0] DUTY_MAX     = 20'd100;
  // round(2^32 / 100): one percent of the phase circle
  localparam logic [31:0]       DUTY_SCALE   = 32'd42_949_673;
  localparam logic [31:0]       INC_RST_DEF  = 32'd8_589_934;
  localparam logic [DUTY_W-1:0] DUTY_RST_DEF = 20'd50;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } upd_state_e;

  function automatic logic [DUTY_W-1:0] duty_sat(input logic [DUTY_W-1:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

endpackage

// File: rtl/dds_pwm_cmp.sv
// Duty threshold (duty * 1% of phase circle) compared against phase, result registered.
// Latency: 1 clk acc_i -> pwm_o; no backpressure.
module dds_pwm_cmp
  import dds_pwm_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              pwm_o
);

  logic [ACC_W-1:0] thr;
  logic             pwm_d;
  logic             pwm_q;

  // 100 % wraps to a tiny threshold, so it is forced high; 0 % falls out as thr=0
  assign thr   = ACC_W'(duty_i) * ACC_W'(DUTY_SCALE);
  assign pwm_d = en_i & ((duty_i == DUTY_MAX) | (acc_i < thr));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/dds_pwm_core.sv
// Phase accumulator with shadowed tuning/duty applied only at phase wrap; drives PWM and sine address.
// Latency: 1 clk acc -> pwm_o/dds_addr_o/sync_o; no backpressure, ready_i is a one-shot strobe.
module dds_pwm_core
  import dds_pwm_pkg::*;
#(
  parameter int                ACC_W    = 32,
  parameter int                ADDR_W   = 8,
  parameter logic [ACC_W-1:0]  INC_RST  = ACC_W'(INC_RST_DEF),
  parameter logic [DUTY_W-1:0] DUTY_RST = DUTY_RST_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ACC_W-1:0]  frq_cnt_i,
  input  logic [DUTY_W-1:0] duty_cnt_i,
  input  logic              ready_i,
  input  logic              en_i,
  output logic              pwm_out_o,
  output logic [ADDR_W-1:0] dds_addr_o,
  output logic              sync_o,
  output logic              upd_pend_o
);

  upd_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  inc_act_q, inc_act_d;
  logic [ACC_W-1:0]  inc_sh_q, inc_sh_d;
  logic [DUTY_W-1:0] duty_act_q, duty_act_d;
  logic [DUTY_W-1:0] duty_sh_q, duty_sh_d;
  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              sync_q;
  logic [ACC_W:0]    sum;
  logic              carry;

  assign sum   = {1'b0, acc_q} + {1'b0, inc_act_q};
  assign carry = sum[ACC_W];

  always_comb begin
    logic apply;
    apply      = 1'b0;
    state_d    = state_q;
    inc_act_d  = inc_act_q;
    duty_act_d = duty_act_q;
    inc_sh_d   = inc_sh_q;
    duty_sh_d  = duty_sh_q;
    acc_d      = en_i ? sum[ACC_W-1:0] : '0;

    case (state_q)
      RUN: begin
        if (ready_q) state_d = PEND;
      end
      PEND: begin
        // a stopped or frozen accumulator never wraps, so apply straight away
        apply = (carry & en_i) | ~en_i | (inc_act_q == '0);
        if (apply) begin
          inc_act_d  = inc_sh_q;
          duty_act_d = duty_sh_q;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // controller data is valid the cycle after its strobe; newest value wins
    if (ready_q) begin
      inc_sh_d  = frq_cnt_i;
      duty_sh_d = duty_sat(duty_cnt_i);
      state_d   = PEND;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      acc_q      <= '0;
      inc_act_q  <= INC_RST;
      inc_sh_q   <= INC_RST;
      duty_act_q <= DUTY_RST;
      duty_sh_q  <= DUTY_RST;
      ready_q    <= 1'b0;
      addr_q     <= '0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      inc_act_q  <= inc_act_d;
      inc_sh_q   <= inc_sh_d;
      duty_act_q <= duty_act_d;
      duty_sh_q  <= duty_sh_d;
      ready_q    <= ready_i;
      addr_q     <= acc_q[ACC_W-1 -: ADDR_W];
      sync_q     <= carry & en_i;
    end
  end

  dds_pwm_cmp #(
    .ACC_W (ACC_W)
  ) u_cmp (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (en_i),
    .acc_i  (acc_q),
    .duty_i (duty_act_q),
    .pwm_o  (pwm_out_o)
  );

  assign dds_addr_o = addr_q;
  assign sync_o     = sync_q;
  assign upd_pend_o = (state_q == PEND);

endmodule

// File: tb/tb_dds_pwm_core.sv
// Bench for dds_pwm_core: arithmetic phase/duty model compared every cycle plus directed period checks.
module tb_dds_pwm_core;

  localparam longint TWO32 = 64'h1_0000_0000;

  logic        clk        = 1'b0;
  logic        rstn       = 1'b0;
  logic [31:0] frq_cnt_i  = '0;
  logic [19:0] duty_cnt_i = '0;
  logic        ready_i    = 1'b0;
  logic        en_i       = 1'b0;
  logic        pwm_out_o;
  logic [7:0]  dds_addr_o;
  logic        sync_o;
  logic        upd_pend_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dds_pwm_core dut (
    .clk        (clk),
    .rstn       (rstn),
    .frq_cnt_i  (frq_cnt_i),
    .duty_cnt_i (duty_cnt_i),
    .ready_i    (ready_i),
    .en_i       (en_i),
    .pwm_out_o  (pwm_out_o),
    .dds_addr_o (dds_addr_o),
    .sync_o     (sync_o),
    .upd_pend_o (upd_pend_o)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_acc, m_inc, m_sh_inc;
  int     m_duty, m_sh_duty;
  bit     m_pend, m_rdy;
  bit     e_pwm, e_sync;
  longint e_addr;

  function automatic longint thr_of(input int d);
    return (longint'(d) * 42949673) % TWO32;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_acc = 0; m_inc = 8589934; m_sh_inc = 8589934;
      m_duty = 50; m_sh_duty = 50; m_pend = 0; m_rdy = 0;
      e_pwm = 0; e_sync = 0; e_addr = 0;
    end else begin
      longint nxt;
      bit     wrap, apply;
      nxt    = m_acc + m_inc;
      wrap   = (nxt >= TWO32);
      e_pwm  = en_i && (m_duty == 100 || m_acc < thr_of(m_duty));
      e_addr = m_acc / (1 << 24);
      e_sync = wrap && en_i;
      apply  = m_pend && ((wrap && en_i) || !en_i || m_inc == 0);
      if (apply) begin
        m_inc  = m_sh_inc;
        m_duty = m_sh_duty;
        m_pend = 0;
      end
      if (m_rdy) begin
        m_sh_inc  = longint'(frq_cnt_i);
        m_sh_duty = (int'(duty_cnt_i) > 100) ? 100 : int'(duty_cnt_i);
        m_pend    = 1;
      end
      m_acc = en_i ? (nxt % TWO32) : 0;
      m_rdy = ready_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pwm_out", longint'(pwm_out_o), longint'(e_pwm));
      chk("dds_addr", longint'(dds_addr_o), e_addr);
      chk("sync", longint'(sync_o), longint'(e_sync));
      chk("upd_pend", longint'(upd_pend_o), longint'(m_pend));
    end
  end

  // period / high-time monitor: each sync closes a period
  int mon_cnt = 0, mon_hi = 0, last_per = 0, last_hi = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      mon_cnt = 0; mon_hi = 0;
    end else begin
      mon_cnt++;
      mon_hi += int'(pwm_out_o);
      if (sync_o) begin
        last_per = mon_cnt; last_hi = mon_hi;
        mon_cnt = 0; mon_hi = 0;
      end
    end
  end

  task automatic wait_sync(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sync_o && n < budget);
    if (!sync_o) begin
      checks++; errors++;
      $display("FAIL sync_timeout: no sync within %0d cycles", budget);
    end
    #1;
  endtask

  task automatic pulse_now(input logic [31:0] f, input logic [19:0] d);
    frq_cnt_i  = f;
    duty_cnt_i = d;
    ready_i    = 1'b1;
    @(negedge clk);
    ready_i    = 1'b0;
  endtask

  initial begin
    bit found;
    // 1. reset
    en_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm", longint'(pwm_out_o), 0);
    chk("rst_addr", longint'(dds_addr_o), 0);
    chk("rst_sync", longint'(sync_o), 0);
    chk("rst_upd", longint'(upd_pend_o), 0);
    chk_en = 1'b1;
    rstn   = 1'b1;
    wait_sync(1200);
    wait_sync(1200);
    chk("rst_period", last_per, 500);
    chk_rng("rst_high", last_hi, 249, 251);
    chk("rst_upd_run", longint'(upd_pend_o), 0);

    // 2. deferred update mid-period
    repeat (100) @(negedge clk);
    pulse_now(32'd17_179_869, 20'd25);
    chk("upd_ready+1", longint'(upd_pend_o), 0);
    @(negedge clk);
    chk("upd_ready+2", longint'(upd_pend_o), 1);
    wait_sync(1200);
    chk("old_period", last_per, 500);
    chk_rng("old_high", last_hi, 249, 251);
    chk("upd_cleared", longint'(upd_pend_o), 0);
    wait_sync(600);
    chk_rng("new_period", last_per, 250, 251);
    chk_rng("new_high", last_hi, 62, 63);

    // 3. duty saturation, glitch-free boundaries
    pulse_now(32'd17_179_869, 20'd150);
    wait_sync(600);
    wait_sync(600);
    chk("sat100_high", last_hi, last_per);
    pulse_now(32'd17_179_869, 20'd0);
    wait_sync(600);
    chk("pre0_high", last_hi, last_per);
    wait_sync(600);
    chk("duty0_high", last_hi, 0);

    // 4. ready_d coincident with carry
    pulse_now(32'd34_359_738, 20'd50);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (m_acc + m_inc < TWO32 && m_acc + 2 * m_inc >= TWO32) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL coincide_search: wrap alignment not found");
    end
    pulse_now(32'd17_179_869, 20'd75);
    @(negedge clk);
    chk("coincide_sync", longint'(sync_o), 1);
    chk("coincide_upd", longint'(upd_pend_o), 1);
    wait_sync(600);
    chk_rng("s1_period", last_per, 125, 126);
    chk("s2_applied_upd", longint'(upd_pend_o), 0);
    wait_sync(600);
    chk_rng("s2_period", last_per, 250, 251);

    // 5. en=0 while pending, then zero tuning word
    pulse_now(32'd25_769_803, 20'd30);
    @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    chk("dis_upd", longint'(upd_pend_o), 0);
    @(negedge clk);
    chk("dis_addr", longint'(dds_addr_o), 0);
    chk("dis_pwm", longint'(pwm_out_o), 0);
    chk("dis_sync", longint'(sync_o), 0);
    pulse_now(32'd0, 20'd40);
    repeat (2) @(negedge clk);
    chk("zero_apply_dis", longint'(upd_pend_o), 0);
    en_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("zero_pwm_static", longint'(pwm_out_o), 1);
    chk("zero_addr_static", longint'(dds_addr_o), 0);
    pulse_now(32'd8_589_934, 20'd50);
    @(negedge clk);
    chk("zero_upd_set", longint'(upd_pend_o), 1);
    @(negedge clk);
    chk("zero_upd_apply", longint'(upd_pend_o), 0);
    wait_sync(1200);

    // 6. mid-run reset while pending
    pulse_now(32'd17_179_869, 20'd10);
    @(negedge clk);
    chk("prerst_upd", longint'(upd_pend_o), 1);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_upd", longint'(upd_pend_o), 0);
    chk("mrst_addr", longint'(dds_addr_o), 0);
    chk("mrst_pwm", longint'(pwm_out_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_sync(1200);
    wait_sync(1200);
    chk("mrst_period", last_per, 500);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ready_i = ($urandom_range(0, 29) == 0);
      if (ready_i) begin
        case ($urandom_range(0, 3))
          0:       frq_cnt_i = 32'd0;
          1:       frq_cnt_i = $urandom();
          2:       frq_cnt_i = $urandom() >> 8;
          default: frq_cnt_i = $urandom() >> 4;
        endcase
        duty_cnt_i = 20'($urandom_range(0, 130));
      end
      if ($urandom_range(0, 199) == 0) en_i = ~en_i;
    end
    @(negedge clk);
    ready_i = 1'b0;
    repeat (5) @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
